// File: rtl/qa_bits_reassembler_if.sv
// qa_bits_reassembler_if
//   Bundles the bit-serial input stream and the reassembled-word outputs of
//   qa_bits_reassembler.
//   Signals:
//     in_data   position or value word from the serial stream
//     in_nd     in_data valid this cycle
//     out_data  reassembled word, held between pulses
//     out_nd    one-cycle pulse, out_data holds a complete new word
//     out_abort one-cycle pulse, a partial word was discarded on restart
//     error     sticky protocol error
//     err_cause 0 none, 1 ERRORCODE received, 2 bad position, 3 bad value
//   Modports:
//     master    stream source and result consumer (drives in_*)
//     slave     the reassembler (drives out_*, error, err_cause)
interface qa_bits_reassembler_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_nd;
    logic [WIDTH-1:0] out_data;
    logic             out_nd;
    logic             out_abort;
    logic             error;
    logic [1:0]       err_cause;

    modport master (
        output in_data, in_nd,
        input  out_data, out_nd, out_abort, error, err_cause
    );

    modport slave (
        input  in_data, in_nd,
        output out_data, out_nd, out_abort, error, err_cause
    );
endinterface

// File: rtl/qa_bits_reassembler.sv
// qa_bits_reassembler
//   Receive-side decoder for the bit-serial QA stream. The input carries
//   alternating (bit position, bit value) words, positions WIDTH-1 down to 0.
//   The original WIDTH-bit word is rebuilt and presented on out_data with a
//   one-cycle out_nd pulse. Protocol violations and the ERRORCODE sentinel
//   latch a sticky error that only reset clears.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high
//     bus    qa_bits_reassembler_if slave modport (stream in, word/status out)
module qa_bits_reassembler #(
    parameter int               WIDTH     = 32,
    parameter int               LOG_WIDTH = 5,
    parameter logic [WIDTH-1:0] ERRORCODE = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    qa_bits_reassembler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXP_VAL,
        EXP_POS,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_SENTINEL = 2'd1,
        CAUSE_POS      = 2'd2,
        CAUSE_VAL      = 2'd3
    } cause_t;

    localparam logic [WIDTH-1:0]     TOP_POS = WIDTH'(WIDTH - 1);
    localparam logic [LOG_WIDTH-1:0] TOP_IDX = LOG_WIDTH'(WIDTH - 1);

    state_t               state_q,    state_d;
    logic [LOG_WIDTH-1:0] exp_pos_q,  exp_pos_d;
    logic [WIDTH-1:0]     asm_q,      asm_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 out_nd_q,   out_nd_d;
    logic                 out_abort_q, out_abort_d;
    logic                 error_q,    error_d;
    cause_t               cause_q,    cause_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            exp_pos_q   <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_nd_q    <= 1'b0;
            out_abort_q <= 1'b0;
            error_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            exp_pos_q   <= exp_pos_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_nd_q    <= out_nd_d;
            out_abort_q <= out_abort_d;
            error_q     <= error_d;
            cause_q     <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_pos_d   = exp_pos_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_nd_d    = 1'b0;
        out_abort_d = 1'b0;
        error_d     = error_q;
        cause_d     = cause_q;

        // ERROR ignores everything; otherwise the sentinel beats any other rule
        if (bus.in_nd && state_q != ERROR) begin
            if (bus.in_data == ERRORCODE) begin
                state_d = ERROR;
                error_d = 1'b1;
                cause_d = CAUSE_SENTINEL;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.in_data == TOP_POS) begin
                            state_d   = EXP_VAL;
                            exp_pos_d = TOP_IDX;
                        end else begin
                            state_d = ERROR;
                            error_d = 1'b1;
                            cause_d = CAUSE_POS;
                        end
                    end
                    EXP_VAL: begin
                        if (bus.in_data[WIDTH-1:1] != '0) begin
                            state_d = ERROR;
                            error_d = 1'b1;
                            cause_d = CAUSE_VAL;
                        end else begin
                            asm_d[exp_pos_q] = bus.in_data[0];
                            if (exp_pos_q == '0) begin
                                // asm_d already has bit 0 merged in
                                out_data_d = asm_d;
                                out_nd_d   = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                exp_pos_d = exp_pos_q - LOG_WIDTH'(1);
                                state_d   = EXP_POS;
                            end
                        end
                    end
                    EXP_POS: begin
                        if (bus.in_data == WIDTH'(exp_pos_q)) begin
                            state_d = EXP_VAL;
                        end else if (bus.in_data == TOP_POS) begin
                            // transmitter restarted with a new word mid-stream
                            out_abort_d = 1'b1;
                            exp_pos_d   = TOP_IDX;
                            state_d     = EXP_VAL;
                        end else begin
                            state_d = ERROR;
                            error_d = 1'b1;
                            cause_d = CAUSE_POS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_nd    = out_nd_q;
    assign bus.out_abort = out_abort_q;
    assign bus.error     = error_q;
    assign bus.err_cause = cause_q;

endmodule
